// File: rtl/eq_regmap_pkg.sv
// Shared constants for the equalizer register map and the SPI register writer.
// Address 0 holds the configuration byte; addresses 1..30 hold ten 24-bit band
// gains, three bytes each, LSB byte first.
// Contents: map constants, command-byte layout, and the writer FSM state type.
package eq_regmap_pkg;

   localparam int unsigned NUM_REGS       = 31;
   localparam int unsigned ADDR_CONFIG    = 0;
   localparam int unsigned GAIN_BASE      = 1;
   localparam int unsigned BYTES_PER_GAIN = 3;
   // Bit of the command byte that selects a write; bits 6:0 carry the address.
   localparam int unsigned CMD_WRITE_BIT  = 7;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCmd   = 2'd1,
      StData  = 2'd2,
      StDrain = 2'd3
   } wr_state_e;

endpackage

// File: rtl/spi_reg_writer_sync.sv
// spi_sync: multi-flop synchronizer with registered edge detect.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   din        asynchronous input
//   level      synchronized level
//   rise/fall  one-clk pulses on a synchronized rising/falling edge
// On reset the chain loads IDLE_VAL so an idle line produces no edge.
module spi_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        IDLE_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE_VAL}};
         prev_q <= IDLE_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 slave turning host frames into reg_map byte writes.
// Frame: command byte {W, A[6:0]} then data bytes, MSB first, sampled on sclk rise.
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   spi_sclk, spi_cs_n, spi_mosi asynchronous SPI inputs
//   reg_we/reg_addr/reg_data     one-clk write strobe with address and byte
//   busy                         frame open (CMD/DATA/DRAIN)
//   frame_err                    one-clk pulse on a protocol error
// Build option: define SPI_AUTOINC_EN for burst writes with address
// auto-increment; otherwise one data byte is written per frame.
module spi_reg_writer
   import eq_regmap_pkg::*;
#(
   parameter int unsigned NUM_REGS    = eq_regmap_pkg::NUM_REGS,
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  reg_we,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [7:0]            reg_data,
   output logic                  busy,
   output logic                  frame_err
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_s;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst   (rst),
      .din   (spi_sclk),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // cs_n edges are swapped: a rising cs_n line is the frame close.
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
      .clk   (clk),
      .rst   (rst),
      .din   (spi_cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   wr_state_e              state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [7:0]             data_q, data_d;
   logic                   we_q, we_d;
   logic                   err_q, err_d;
   logic                   ovf_q, ovf_d;
   // armed_q blocks frame entry until cs_n has been seen high after reset,
   // so a frame already open at reset release is never joined mid-way.
   logic                   armed_q, armed_d;
   logic [SYNC_STAGES-1:0] settle_q;

   logic [7:0]  shift_nxt;
   logic        byte_done;
   logic [31:0] cmd_addr;

   assign shift_nxt = {shift_q[6:0], mosi_s};
   assign byte_done = (bit_cnt_q == 3'd7);
   assign cmd_addr  = 32'(shift_nxt[6:0]);
   assign mosi_s    = mosi_q[SYNC_STAGES-1];

`ifdef SPI_AUTOINC_EN
   logic [31:0] next_addr;
   assign next_addr = 32'(cur_addr_q) + 32'd1;
`endif

   logic unused_sig;
   assign unused_sig = ^{sclk_lvl, sclk_fall, shift_q[7]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         cur_addr_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
         armed_q    <= 1'b0;
         settle_q   <= '0;
         mosi_q     <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         cur_addr_q <= cur_addr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         we_q       <= we_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
         armed_q    <= armed_d;
         settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
         mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      cur_addr_d = cur_addr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      we_d       = 1'b0;
      err_d      = 1'b0;
      ovf_d      = ovf_q;
      // cs level is only trustworthy once real input has filled the chain.
      armed_d    = armed_q | (settle_q[SYNC_STAGES-1] & cs_lvl);

      if (cs_rise) begin
         // Close wins over a coincident sclk rise; a partial byte is an error.
         if (state_q != StIdle && bit_cnt_q != 3'd0) err_d = 1'b1;
         state_d   = StIdle;
         bit_cnt_d = '0;
         ovf_d     = 1'b0;
      end else if (state_q == StIdle) begin
         if (cs_fall && armed_q) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            ovf_d     = 1'b0;
         end
      end else if (sclk_rise) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shift_d   = shift_nxt;
         if (byte_done) begin
            case (state_q)
               StCmd: begin
                  if (shift_nxt[CMD_WRITE_BIT]) begin
                     if (cmd_addr < NUM_REGS) begin
                        state_d    = StData;
                        cur_addr_d = shift_nxt[ADDR_WIDTH-1:0];
                     end else begin
                        state_d = StDrain;
                        err_d   = 1'b1;
                     end
                  end else begin
                     state_d = StDrain;
                  end
               end
               StData: begin
                  we_d   = 1'b1;
                  addr_d = cur_addr_q;
                  data_d = shift_nxt;
`ifdef SPI_AUTOINC_EN
                  // No wrap to address 0: the next full byte is reported instead.
                  if (next_addr == NUM_REGS) begin
                     state_d = StDrain;
                     ovf_d   = 1'b1;
                  end else begin
                     cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                  end
`else
                  state_d = StDrain;
`endif
               end
               StDrain: begin
                  if (ovf_q) begin
                     err_d = 1'b1;
                     ovf_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      reg_we    = we_q;
      reg_addr  = addr_q;
      reg_data  = data_q;
      frame_err = err_q;
      busy      = (state_q != StIdle);
   end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer: table of SPI frames with expected
// writes/errors, plus hand sequences for reset state and mid-frame reset.
module tb_spi_reg_writer;

   localparam int LAT = 4;  // SYNC_STAGES + 2

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sclk, spi_cs_n, spi_mosi;
   logic       reg_we;
   logic [4:0] reg_addr;
   logic [7:0] reg_data;
   logic       busy, frame_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_reg_writer dut (
      .clk       (clk),
      .rst       (rst),
      .spi_sclk  (spi_sclk),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_data  (reg_data),
      .busy      (busy),
      .frame_err (frame_err)
   );

   // Write / error log sampled on the falling clock edge
   int         cyc = 0;
   int         last_rise = 0;
   logic [4:0] wr_a[$];
   logic [7:0] wr_d[$];
   int         wr_lat[$];
   int         err_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge spi_sclk) last_rise = cyc;
   always @(negedge clk) begin
      if (reg_we === 1'b1) begin
         wr_a.push_back(reg_addr);
         wr_d.push_back(reg_data);
         wr_lat.push_back(cyc - last_rise);
      end
      if (frame_err === 1'b1) err_cnt++;
   end

   typedef struct {
      logic [31:0]     bytes;  // first byte in bits 31:24
      int              nb;
      int              tail;   // extra bits taken from the next byte
      int              nw;
      logic [2:0][4:0] wa;     // wa[0] is the first write
      logic [2:0][7:0] wd;
      int              ne;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] b, input int nb, input int tail,
                               input int nw, input logic [2:0][4:0] wa,
                               input logic [2:0][7:0] wd, input int ne);
      vec_t v;
      v.bytes = b; v.nb = nb; v.tail = tail; v.nw = nw; v.wa = wa; v.wd = wd; v.ne = ne;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic half();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         spi_mosi = b[7-i];
         half();
         spi_sclk = 1'b1;
         half();
         spi_sclk = 1'b0;
      end
   endtask

   task automatic clear_log();
      wr_a.delete();
      wr_d.delete();
      wr_lat.delete();
      err_cnt = 0;
   endtask

   task automatic run_frame(input string tag, input vec_t v);
      spi_cs_n = 1'b0;
      half();
      half();
      chk({tag, "_busy_open"}, 32'(busy), 32'd1);
      for (int i = 0; i < v.nb; i++) send_bits(v.bytes[31-8*i -: 8], 8);
      if (v.tail > 0) send_bits(v.bytes[31-8*v.nb -: 8], v.tail);
      half();
      spi_cs_n = 1'b1;
      repeat (4) half();
   endtask

   task automatic check_frame(input string tag, input vec_t v);
      chk({tag, "_nwrites"}, 32'(wr_a.size()), 32'(v.nw));
      for (int i = 0; i < v.nw && i < wr_a.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(wr_a[i]), 32'(v.wa[i]));
         chk($sformatf("%s_data%0d", tag, i), 32'(wr_d[i]), 32'(v.wd[i]));
         chk($sformatf("%s_lat%0d", tag, i), 32'(wr_lat[i]), 32'(LAT));
      end
      chk({tag, "_errs"}, 32'(err_cnt), 32'(v.ne));
      chk({tag, "_busy_closed"}, 32'(busy), 32'd0);
   endtask

   vec_t vecs[8];

   initial begin
`ifdef SPI_AUTOINC_EN
      vecs[1] = mk(32'h84C7711C, 4, 0, 3, {5'd6, 5'd5, 5'd4}, {8'h1C, 8'h71, 8'hC7}, 0);
      vecs[2] = mk(32'h9EFFEE00, 3, 0, 1, {5'd0, 5'd0, 5'd30}, {8'h0, 8'h0, 8'hFF}, 1);
      vecs[7] = mk(32'h9D112200, 3, 0, 2, {5'd0, 5'd30, 5'd29}, {8'h0, 8'h22, 8'h11}, 0);
`else
      vecs[1] = mk(32'h84C7711C, 4, 0, 1, {5'd0, 5'd0, 5'd4}, {8'h0, 8'h0, 8'hC7}, 0);
      vecs[2] = mk(32'h9EFFEE00, 3, 0, 1, {5'd0, 5'd0, 5'd30}, {8'h0, 8'h0, 8'hFF}, 0);
      vecs[7] = mk(32'h9D112200, 3, 0, 1, {5'd0, 5'd0, 5'd29}, {8'h0, 8'h0, 8'h11}, 0);
`endif
      vecs[0] = mk(32'h80AA0000, 2, 0, 1, {5'd0, 5'd0, 5'd0}, {8'h0, 8'h0, 8'hAA}, 0);
      vecs[3] = mk(32'hA0120000, 2, 0, 0, '0, '0, 1);  // address 32 out of range
      vecs[4] = mk(32'h05120000, 2, 0, 0, '0, '0, 0);  // read command: drained
      vecs[5] = mk(32'h81FF0000, 1, 5, 0, '0, '0, 1);  // partial data byte
      vecs[6] = mk(32'h813C0000, 2, 0, 1, {5'd0, 5'd0, 5'd1}, {8'h0, 8'h0, 8'h3C}, 0);

      rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_we", 32'(reg_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      repeat (2) half();

      for (int i = 0; i < 8; i++) begin
         clear_log();
         run_frame($sformatf("v%0d", i), vecs[i]);
         check_frame($sformatf("v%0d", i), vecs[i]);
      end

      // Mid-frame reset with cs_n held low through release
      clear_log();
      spi_cs_n = 1'b0;
      half();
      half();
      send_bits(8'h81, 8);
      send_bits(8'hF0, 4);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_we", 32'(reg_we), 32'd0);
      chk("midrst_addr", 32'(reg_addr), 32'd0);
      chk("midrst_data", 32'(reg_data), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      half();
      // A byte-aligned write attempt in the still-open frame must be ignored
      send_bits(8'h81, 8);
      send_bits(8'h77, 8);
      chk("midrst_busy_after", 32'(busy), 32'd0);
      half();
      spi_cs_n = 1'b1;
      repeat (4) half();
      chk("midrst_nwrites", 32'(wr_a.size()), 32'd0);
      chk("midrst_errs", 32'(err_cnt), 32'd0);

      clear_log();
      run_frame("post", vecs[6]);
      check_frame("post", vecs[6]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500us;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
